// File: rtl/ni_enq_sched.sv
// ni_enq_sched: dedup/pack dd_core enqueue candidates into the non-idle FIFO and hold its head for the transport core
// Optional round-robin candidate priority: define NI_SCHED_RR_EN
module ni_enq_sched #(
   parameter int                FID_W      = 10,
   parameter int                FLOW_CNT   = 1024,
   parameter int                FIFO_DEPTH = 1024,
   parameter logic [FID_W-1:0]  FID_NONE   = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FID_W-1:0] cand_fid_0,
   input  logic [FID_W-1:0] cand_fid_1,
   input  logic [FID_W-1:0] cand_fid_2,
   input  logic [FID_W-1:0] cand_fid_3,
   output logic             wr_val_0,
   output logic             wr_val_1,
   output logic             wr_val_2,
   output logic             wr_val_3,
   output logic [FID_W-1:0] wr_data_0,
   output logic [FID_W-1:0] wr_data_1,
   output logic [FID_W-1:0] wr_data_2,
   output logic [FID_W-1:0] wr_data_3,
   output logic             fifo_rd,
   input  logic [FID_W-1:0] fifo_rd_data,
   input  logic             fifo_data_avail,
   output logic             deq_val,
   output logic [FID_W-1:0] deq_fid,
   input  logic             deq_ack,
   output logic [15:0]      drop_cnt
);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 2);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t              state, state_nx;
   logic [FID_W-1:0]    c_q [4];
   logic [FID_W-1:0]    p_fid [4];
   logic [3:0]          elig;
   logic                w_val [4];
   logic [FID_W-1:0]    w_data [4];
   logic                wv_q [4];
   logic [FID_W-1:0]    wd_q [4];
   logic [FLOW_CNT-1:0] queued, queued_nx;
   logic [OCC_W-1:0]    occ;
   logic [OCC_W:0]      space;
   logic [2:0]          cap, n_acc, n_drop;
   logic [16:0]         drop_sum;
   logic                rel, deq_val_nx;
   logic [FID_W-1:0]    deq_fid_nx;
`ifdef NI_SCHED_RR_EN
   logic [1:0]          rr_ptr;
`endif

   assign rel = deq_ack & deq_val;
   assign {wr_val_3, wr_val_2, wr_val_1, wr_val_0} = {wv_q[3], wv_q[2], wv_q[1], wv_q[0]};
   assign {wr_data_3, wr_data_2, wr_data_1, wr_data_0} = {wd_q[3], wd_q[2], wd_q[1], wd_q[0]};

   // Filter, capacity limit and contiguous packing of the registered candidates
   always_comb begin
      for (int i = 0; i < 4; i++) begin
`ifdef NI_SCHED_RR_EN
         p_fid[i] = c_q[rr_ptr + 2'(i)];
`else
         p_fid[i] = c_q[i];
`endif
      end
      for (int i = 0; i < 4; i++) begin
         elig[i] = p_fid[i] != FID_NONE && (!queued[p_fid[i]] || (rel && deq_fid == p_fid[i]));
         for (int j = 0; j < i; j++)
            if (elig[j] && p_fid[j] == p_fid[i]) elig[i] = 1'b0;
      end
      space = ({1'b0, occ} >= (OCC_W+1)'(FIFO_DEPTH)) ? (OCC_W+1)'(rel)
            : (OCC_W+1)'(FIFO_DEPTH) - {1'b0, occ} + (OCC_W+1)'(rel);
      cap = (space > (OCC_W+1)'(4)) ? 3'd4 : space[2:0];
      n_acc = '0;
      n_drop = '0;
      for (int i = 0; i < 4; i++) begin
         w_val[i] = 1'b0;
         w_data[i] = FID_NONE;
      end
      for (int i = 0; i < 4; i++) begin
         if (elig[i] && n_acc < cap) begin
            w_val[n_acc[1:0]] = 1'b1;
            w_data[n_acc[1:0]] = p_fid[i];
            n_acc = n_acc + 3'd1;
         end else if (elig[i]) begin
            n_drop = n_drop + 3'd1;
         end
      end
      queued_nx = queued;
      if (rel) queued_nx[deq_fid] = 1'b0;
      for (int i = 0; i < 4; i++)
         if (w_val[i]) queued_nx[w_data[i]] = 1'b1;
      drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
   end

   // Dequeue sequencing: pop in IDLE, capture in FETCH, hold until acked
   always_comb begin
      state_nx = state;
      fifo_rd = 1'b0;
      deq_val_nx = deq_val;
      deq_fid_nx = deq_fid;
      if (state == IDLE && fifo_data_avail && !rst) begin
         fifo_rd = 1'b1;
         state_nx = FETCH;
      end else if (state == FETCH) begin
         state_nx = HOLD;
         deq_val_nx = 1'b1;
         deq_fid_nx = fifo_rd_data;
      end else if (state == HOLD && deq_ack) begin
         state_nx = IDLE;
         deq_val_nx = 1'b0;
         deq_fid_nx = FID_NONE;
      end
   end

   // State registers: candidate stage, write ports, bitmap, occupancy, drops, head
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            c_q[i] <= FID_NONE;
            wv_q[i] <= 1'b0;
            wd_q[i] <= FID_NONE;
         end
         queued <= '0;
         occ <= '0;
         drop_cnt <= '0;
         state <= IDLE;
         deq_val <= 1'b0;
         deq_fid <= FID_NONE;
      end else begin
         c_q[0] <= cand_fid_0;
         c_q[1] <= cand_fid_1;
         c_q[2] <= cand_fid_2;
         c_q[3] <= cand_fid_3;
         for (int i = 0; i < 4; i++) begin
            wv_q[i] <= w_val[i];
            wd_q[i] <= w_data[i];
         end
         queued <= queued_nx;
         occ <= occ + OCC_W'(n_acc) - OCC_W'(rel);
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         state <= state_nx;
         deq_val <= deq_val_nx;
         deq_fid <= deq_fid_nx;
      end
   end

`ifdef NI_SCHED_RR_EN
   // Rotate the starting priority port whenever something was dropped
   always_ff @(posedge clk) begin
      if (rst) rr_ptr <= '0;
      else if (n_drop != 3'd0) rr_ptr <= rr_ptr + 2'd1;
   end
`endif

endmodule

// File: tb/tb_ni_enq_sched.sv
// tb_ni_enq_sched: directed self-checking bench for ni_enq_sched with a small FIFO model (FIFO_DEPTH=4)
module tb_ni_enq_sched;
   localparam logic [9:0] NONE = 10'h3FF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] cand_fid_0 = NONE, cand_fid_1 = NONE, cand_fid_2 = NONE, cand_fid_3 = NONE;
   logic       wr_val_0, wr_val_1, wr_val_2, wr_val_3;
   logic [9:0] wr_data_0, wr_data_1, wr_data_2, wr_data_3;
   logic       fifo_rd;
   logic [9:0] fifo_rd_data = NONE;
   logic       fifo_data_avail = 1'b0;
   logic       deq_val;
   logic [9:0] deq_fid;
   logic       deq_ack = 1'b0;
   logic [15:0] drop_cnt;
   int n_cmp = 0;
   int n_err = 0;
   logic [9:0] fq[$];

   ni_enq_sched #(.FID_W(10), .FLOW_CNT(1024), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cand_fid_0(cand_fid_0), .cand_fid_1(cand_fid_1), .cand_fid_2(cand_fid_2), .cand_fid_3(cand_fid_3),
      .wr_val_0(wr_val_0), .wr_val_1(wr_val_1), .wr_val_2(wr_val_2), .wr_val_3(wr_val_3),
      .wr_data_0(wr_data_0), .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .wr_data_3(wr_data_3),
      .fifo_rd(fifo_rd), .fifo_rd_data(fifo_rd_data), .fifo_data_avail(fifo_data_avail),
      .deq_val(deq_val), .deq_fid(deq_fid), .deq_ack(deq_ack), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // FIFO model: pop on fifo_rd (data next cycle), push write ports in order
   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
         fifo_rd_data <= NONE;
      end else begin
         if (fifo_rd && fq.size() != 0) fifo_rd_data <= fq.pop_front();
         if (wr_val_0) fq.push_back(wr_data_0);
         if (wr_val_1) fq.push_back(wr_data_1);
         if (wr_val_2) fq.push_back(wr_data_2);
         if (wr_val_3) fq.push_back(wr_data_3);
      end
      fifo_data_avail <= !rst && fq.size() != 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_c(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
      cand_fid_0 = a;
      cand_fid_1 = b;
      cand_fid_2 = c;
      cand_fid_3 = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      deq_ack = 1'b0;
      set_c(NONE, NONE, NONE, NONE);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_head(input string name);
      for (int i = 0; i < 20 && !deq_val; i++) tick();
      n_cmp++;
      if (deq_val !== 1'b1) begin
         n_err++;
         $display("FAIL %s: deq_val timeout, got %b want 1", name, deq_val);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({wr_val_3, wr_val_2, wr_val_1, wr_val_0, fifo_rd, deq_val} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_strobes: got %b want 000000", {wr_val_3, wr_val_2, wr_val_1, wr_val_0, fifo_rd, deq_val});
      end
      n_cmp++;
      if ({wr_data_3, wr_data_2, wr_data_1, wr_data_0, deq_fid} !== {5{NONE}}) begin
         n_err++;
         $display("FAIL reset_data: got %h %h %h %h %h want all 3ff", wr_data_3, wr_data_2, wr_data_1, wr_data_0, deq_fid);
      end
      n_cmp++;
      if (drop_cnt !== 16'd0 || dut.occ !== '0) begin
         n_err++;
         $display("FAIL reset_cnt: drop_cnt %0d occ %0d want 0 0", drop_cnt, dut.occ);
      end
   endtask

   task automatic test_dedup_pack();
      set_c(10'd5, 10'd9, NONE, 10'd5);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      n_cmp++;
      if ({wr_val_3, wr_val_2, wr_val_1, wr_val_0} !== 4'b0011) begin
         n_err++;
         $display("FAIL pack_val: got %b want 0011", {wr_val_3, wr_val_2, wr_val_1, wr_val_0});
      end
      n_cmp++;
      if ({wr_data_0, wr_data_1, wr_data_2, wr_data_3} !== {10'd5, 10'd9, NONE, NONE}) begin
         n_err++;
         $display("FAIL pack_data: got %0d %0d %0d %0d want 5 9 1023 1023", wr_data_0, wr_data_1, wr_data_2, wr_data_3);
      end
      n_cmp++;
      if (dut.occ !== 3'd2 || drop_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL pack_occ: occ %0d drop %0d want 2 0", dut.occ, drop_cnt);
      end
   endtask

   task automatic test_requeue();
      wait_head("requeue_head");
      n_cmp++;
      if (deq_fid !== 10'd5) begin
         n_err++;
         $display("FAIL requeue_fid: got %0d want 5", deq_fid);
      end
      set_c(10'd5, NONE, NONE, NONE);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      n_cmp++;
      if (wr_val_0 !== 1'b0 || drop_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL requeue_blocked: wr_val_0 %b drop %0d want 0 0", wr_val_0, drop_cnt);
      end
      set_c(10'd5, NONE, NONE, NONE);
      tick();
      deq_ack = 1'b1;
      set_c(NONE, NONE, NONE, NONE);
      tick();
      deq_ack = 1'b0;
      n_cmp++;
      if (wr_val_0 !== 1'b1 || wr_data_0 !== 10'd5 || dut.queued[5] !== 1'b1) begin
         n_err++;
         $display("FAIL requeue_ack: wr_val_0 %b data %0d queued %b want 1 5 1", wr_val_0, wr_data_0, dut.queued[5]);
      end
      n_cmp++;
      if (dut.occ !== 3'd2 || deq_val !== 1'b0) begin
         n_err++;
         $display("FAIL requeue_occ: occ %0d deq_val %b want 2 0", dut.occ, deq_val);
      end
   endtask

   task automatic test_capacity();
      int port;
      logic [9:0] b;
      do_reset();
      set_c(10'd10, 10'd11, 10'd12, NONE);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      wait_head("cap_head");
      n_cmp++;
      if (dut.occ !== 3'd3) begin
         n_err++;
         $display("FAIL cap_occ3: got %0d want 3", dut.occ);
      end
      set_c(10'd1, 10'd2, 10'd3, 10'd4);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      n_cmp++;
      if ({wr_val_3, wr_val_2, wr_val_1, wr_val_0} !== 4'b0001 || wr_data_0 !== 10'd1 || drop_cnt !== 16'd3) begin
         n_err++;
         $display("FAIL cap_first: val %b data %0d drop %0d want 0001 1 3", {wr_val_3, wr_val_2, wr_val_1, wr_val_0}, wr_data_0, drop_cnt);
      end
      n_cmp++;
      if (dut.occ !== 3'd4) begin
         n_err++;
         $display("FAIL cap_occ4: got %0d want 4", dut.occ);
      end
      for (int r = 1; r < 4; r++) begin
         wait_head("cap_round_head");
         b = 10'(20 + 4 * r);
`ifdef NI_SCHED_RR_EN
         port = r;
`else
         port = 0;
`endif
         set_c(b, b + 10'd1, b + 10'd2, b + 10'd3);
         tick();
         deq_ack = 1'b1;
         set_c(NONE, NONE, NONE, NONE);
         tick();
         deq_ack = 1'b0;
         n_cmp++;
         if ({wr_val_3, wr_val_2, wr_val_1, wr_val_0} !== 4'b0001 || wr_data_0 !== b + 10'(port) || drop_cnt !== 16'(3 * (r + 1))) begin
            n_err++;
            $display("FAIL cap_round%0d: val %b data %0d drop %0d want 0001 %0d %0d", r, {wr_val_3, wr_val_2, wr_val_1, wr_val_0}, wr_data_0, drop_cnt, b + 10'(port), 3 * (r + 1));
         end
      end
   endtask

   task automatic test_dequeue();
      do_reset();
      set_c(10'd7, 10'd8, NONE, NONE);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      tick();
      n_cmp++;
      if (fifo_rd !== 1'b1 || deq_val !== 1'b0) begin
         n_err++;
         $display("FAIL deq_pop: fifo_rd %b deq_val %b want 1 0", fifo_rd, deq_val);
      end
      tick();
      n_cmp++;
      if (fifo_rd !== 1'b0) begin
         n_err++;
         $display("FAIL deq_pulse: fifo_rd %b want 0", fifo_rd);
      end
      tick();
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (deq_val !== 1'b1 || deq_fid !== 10'd7 || fifo_rd !== 1'b0) begin
            n_err++;
            $display("FAIL deq_hold%0d: val %b fid %0d rd %b want 1 7 0", i, deq_val, deq_fid, fifo_rd);
         end
         tick();
      end
      deq_ack = 1'b1;
      tick();
      deq_ack = 1'b0;
      n_cmp++;
      if (deq_val !== 1'b0 || deq_fid !== NONE) begin
         n_err++;
         $display("FAIL deq_ack: val %b fid %0d want 0 1023", deq_val, deq_fid);
      end
      tick();
      tick();
      n_cmp++;
      if (deq_val !== 1'b1 || deq_fid !== 10'd8) begin
         n_err++;
         $display("FAIL deq_next: val %b fid %0d want 1 8", deq_val, deq_fid);
      end
   endtask

   task automatic test_drop_sat();
      do_reset();
      set_c(10'd1, 10'd2, 10'd3, 10'd4);
      tick();
      set_c(10'd100, 10'd101, 10'd102, 10'd103);
      tick();
      tick();
      n_cmp++;
      if (drop_cnt !== 16'd4) begin
         n_err++;
         $display("FAIL sat_first: got %0d want 4", drop_cnt);
      end
      for (int i = 0; i < 16382; i++) tick();
      n_cmp++;
      if (drop_cnt !== 16'd65532) begin
         n_err++;
         $display("FAIL sat_edge: got %0d want 65532", drop_cnt);
      end
      tick();
      n_cmp++;
      if (drop_cnt !== 16'hFFFF) begin
         n_err++;
         $display("FAIL sat_clip: got %h want ffff", drop_cnt);
      end
      for (int i = 0; i < 1200; i++) tick();
      n_cmp++;
      if (drop_cnt !== 16'hFFFF) begin
         n_err++;
         $display("FAIL sat_hold: got %h want ffff", drop_cnt);
      end
      set_c(NONE, NONE, NONE, NONE);
   endtask

   task automatic test_reset_hold();
      do_reset();
      set_c(10'd1, 10'd2, 10'd3, NONE);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      wait_head("rh_head");
      n_cmp++;
      if (dut.occ !== 3'd3 || deq_fid !== 10'd1) begin
         n_err++;
         $display("FAIL rh_pre: occ %0d fid %0d want 3 1", dut.occ, deq_fid);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({wr_val_3, wr_val_2, wr_val_1, wr_val_0, fifo_rd, deq_val} !== 6'b0 || deq_fid !== NONE || wr_data_0 !== NONE || drop_cnt !== 16'd0 || dut.occ !== '0) begin
         n_err++;
         $display("FAIL rh_reset: strobes %b fid %0d wd0 %0d drop %0d occ %0d want 0 1023 1023 0 0", {wr_val_3, wr_val_2, wr_val_1, wr_val_0, fifo_rd, deq_val}, deq_fid, wr_data_0, drop_cnt, dut.occ);
      end
      rst = 1'b0;
      set_c(10'd2, NONE, NONE, NONE);
      tick();
      set_c(NONE, NONE, NONE, NONE);
      tick();
      n_cmp++;
      if (wr_val_0 !== 1'b1 || wr_data_0 !== 10'd2) begin
         n_err++;
         $display("FAIL rh_requeue: val %b data %0d want 1 2", wr_val_0, wr_data_0);
      end
   endtask

   initial begin
      test_reset();
      test_dedup_pack();
      test_requeue();
      test_capacity();
      test_dequeue();
      test_drop_sat();
      test_reset_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ni_enq_sched.md
Name: ni_enq_sched

Overview:
Scheduler between dd_core's four per-cycle enqueue candidates and the 4-write-port non-idle flow FIFO.
- Deduplicates flows so each flow ID is in the FIFO at most once.
- Packs the accepted IDs onto the FIFO write ports and enforces FIFO capacity.
- Sequences FIFO reads into a held head-of-queue with a valid/ack handshake toward the transport core.

Parameters:
FID_W, 10, flow ID width
FLOW_CNT, 1024, number of flows (bitmap size)
FIFO_DEPTH, 1024, non-idle FIFO capacity; may be less than FLOW_CNT
FID_NONE, 1023, reserved "no flow" encoding (all ones of FID_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cand_fid_0..cand_fid_3  in  FID_W each  enqueue candidates from dd_core; FID_NONE = no request
wr_val_0..wr_val_3  out  1 each  FIFO write strobes, registered
wr_data_0..wr_data_3  out  FID_W each  FIFO write data, registered
fifo_rd  out  1  FIFO pop strobe (single-cycle pulse)
fifo_rd_data  in  FID_W  FIFO head; valid the cycle after fifo_rd
fifo_data_avail  in  1  FIFO non-empty
deq_val  out  1  deq_fid valid
deq_fid  out  FID_W  current head flow; FID_NONE when deq_val=0
deq_ack  in  1  consumer takes deq_fid; ignored when deq_val=0
drop_cnt  out  16  saturating count of candidates dropped for lack of space

Behaviour:
- Reset values:
  - all wr_val=0, all wr_data=FID_NONE, fifo_rd=0, deq_val=0, deq_fid=FID_NONE, drop_cnt=0.
  - queued bitmap all 0, occ=0, rr_ptr=0, FSM in IDLE.
  - A reset mid-operation discards all state; the integrator resets the FIFO with the same rst.
- Stage 1: cand_fid_k is registered into c_q[k] every cycle.
- Stage 2 filter, combinational on c_q. Candidate k is eligible when all hold:
  - c_q[k] != FID_NONE;
  - queued[c_q[k]]=0, OR that flow is being released by deq_ack this cycle;
  - no lower-priority-order eligible candidate carries the same ID. Same-cycle duplicates collapse to one; they are not drops.
- Capacity:
  - occ counts entries in the FIFO plus the held head; max FIFO_DEPTH+1 is never reached.
  - space = FIFO_DEPTH - occ + (deq_ack & deq_val).
  - The first min(eligible, space) eligible candidates in priority order are accepted.
  - Remaining eligible candidates are dropped; drop_cnt increments by the drop count and saturates at 16'hFFFF.
- Packing: accepted IDs drive wr ports 0..n-1 contiguously, in priority order; unused ports get wr_val=0 and wr_data=FID_NONE.
- Latency: cand_fid at edge t appears on wr_* after edge t+2.
- Registering edge: queued[id] is set and occ += n at the edge that registers the writes.
- Dequeue FSM:
  - IDLE: if fifo_data_avail, pulse fifo_rd and go to FETCH.
  - FETCH: capture fifo_rd_data into deq_fid, set deq_val=1, go to HOLD.
  - HOLD: on deq_ack, clear queued[deq_fid], occ -= 1, set deq_val=0 and deq_fid=FID_NONE, go to IDLE.
  - Throughput: one head per 3 cycles minimum.
- Simultaneous events:
  - Ack and re-enqueue of the same ID in one cycle: the set wins, so the ID is accepted.
  - Ack and accepted writes in one cycle: occ = occ + n - 1.
- Width rules: occ is $clog2(FIFO_DEPTH+2) bits; space is computed without underflow; drop_cnt saturates.

Optional Feature:
NI_SCHED_RR_EN
- Defined: priority order starts at port rr_ptr and wraps (rr_ptr, rr_ptr+1, ... mod 4). rr_ptr increments mod 4 on every cycle with at least one drop, so no candidate port is starved under sustained backpressure.
- Undefined: fixed priority, port 0 highest; rr_ptr logic is absent.

Test Plan:
- Reset, then cand_0..3 = 5, 9, NONE, 5 in one cycle -> two cycles later wr_val=1,1,0,0 with wr_data=5,9; occ=2; drop_cnt=0.
- Flow 5 is queued and cand_0=5 is presented again -> no write, drop_cnt unchanged. Ack flow 5 in the same cycle that cand_q holds 5 -> 5 is re-written, queued[5]=1.
- FIFO_DEPTH=4, occ=3, cand_0..3 = 1, 2, 3, 4 with fixed priority -> only 1 written, drop_cnt=3. With NI_SCHED_RR_EN, repeating this shows the accepted port rotating 0, 1, 2, 3.
- FIFO holds 7 then 8 -> fifo_rd pulse, then deq_val=1/deq_fid=7. Holding deq_ack=0 for 10 cycles keeps deq_fid=7 stable. Ack -> IDLE, then deq_fid=8 appears 2 cycles later.
- Force 70000 drops -> drop_cnt holds at 16'hFFFF.
- Assert rst during HOLD with occ=3 -> next cycle all outputs at reset values; afterwards a previously queued flow is accepted again.
